// File: rtl/rv_mem_model_if.sv
// Request/response bundle for the two-port memory responder: one instruction
// read port and one data read/write port, each with a valid/ready request and
// a one-cycle response pulse.
interface rv_mem_model_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rvalid, i_rdata, i_err,
    output d_valid, d_addr, d_we, d_be, d_wdata,
    input  d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rvalid, i_rdata, i_err,
    input  d_valid, d_addr, d_we, d_be, d_wdata,
    output d_ready, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/rv_mem_model.sv
// Two-port memory responder with per-port wait states, byte-enabled data
// writes, out-of-range error flagging and a tohost completion register.
// The access is performed at the edge that raises rvalid, so rdata is
// already registered during the response cycle.
module rv_mem_model #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 4096,
  parameter int unsigned       I_WAIT      = 0,
  parameter int unsigned       D_WAIT      = 0,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_F000),
  parameter string             INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rst,
  rv_mem_model_if.slave      bus,
  output logic               done,
  output logic [DATA_W-1:0]  exit_code
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [ADDR_W-1:0] TOHOST_IDX = TOHOST_ADDR >> OFF_W;
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            i_state, i_state_d;
  logic [CNT_W-1:0]  i_cnt, i_cnt_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, i_cur_c, i_idx_c;
  logic              i_acc_c, i_host_c, i_oor_c;
  logic [DATA_W-1:0] i_rdata_c;

  state_t            d_state, d_state_d;
  logic [CNT_W-1:0]  d_cnt, d_cnt_d;
  dreq_t             d_req_q, d_req_d, d_cur_c;
  logic [ADDR_W-1:0] d_idx_c;
  logic              d_acc_c, d_host_c, d_oor_c, d_wr_c, d_host_wr_c;
  logic [DATA_W-1:0] d_rdata_c;

  // instruction port next state; i_acc_c marks the edge that performs the read
  always_comb begin
    i_state_d = i_state;
    i_cnt_d   = i_cnt;
    i_addr_d  = i_addr_q;
    i_acc_c   = 1'b0;
    i_cur_c   = i_addr_q;
    case (i_state)
      IDLE, RESP: begin
        i_state_d = IDLE;
        if (bus.i_valid) begin
          i_addr_d = bus.i_addr;
          i_cnt_d  = CNT_W'(I_WAIT);
          if (I_WAIT == 0) begin
            i_state_d = RESP;
            i_acc_c   = 1'b1;
            i_cur_c   = bus.i_addr;
          end else begin
            i_state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (i_cnt == CNT_W'(1)) begin
          i_state_d = RESP;
          i_acc_c   = 1'b1;
        end else begin
          i_cnt_d = i_cnt - CNT_W'(1);
        end
      end
      default: i_state_d = IDLE;
    endcase
  end

  // instruction address decode and read data selection
  always_comb begin
    i_idx_c  = i_cur_c >> OFF_W;
    i_host_c = (i_idx_c == TOHOST_IDX);
    i_oor_c  = !i_host_c && (i_idx_c >= DEPTH_A);
    if (i_host_c)     i_rdata_c = exit_code;
    else if (i_oor_c) i_rdata_c = '0;
    else              i_rdata_c = mem[i_idx_c[IDX_W-1:0]];
  end

  // instruction port state and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state      <= IDLE;
      i_cnt        <= '0;
      i_addr_q     <= '0;
      bus.i_ready  <= 1'b1;
      bus.i_rvalid <= 1'b0;
      bus.i_rdata  <= '0;
      bus.i_err    <= 1'b0;
    end else begin
      i_state      <= i_state_d;
      i_cnt        <= i_cnt_d;
      i_addr_q     <= i_addr_d;
      bus.i_ready  <= (i_state_d != BUSY);
      bus.i_rvalid <= i_acc_c;
      if (i_acc_c) begin
        bus.i_rdata <= i_rdata_c;
        bus.i_err   <= i_oor_c;
      end
    end
  end

  // data port next state; the request is latched so inputs may drop after acceptance
  always_comb begin
    d_state_d = d_state;
    d_cnt_d   = d_cnt;
    d_req_d   = d_req_q;
    d_acc_c   = 1'b0;
    d_cur_c   = d_req_q;
    case (d_state)
      IDLE, RESP: begin
        d_state_d = IDLE;
        if (bus.d_valid) begin
          d_req_d.addr  = bus.d_addr;
          d_req_d.we    = bus.d_we;
          d_req_d.be    = bus.d_be;
          d_req_d.wdata = bus.d_wdata;
          d_cnt_d       = CNT_W'(D_WAIT);
          if (D_WAIT == 0) begin
            d_state_d = RESP;
            d_acc_c   = 1'b1;
            d_cur_c   = d_req_d;
          end else begin
            d_state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (d_cnt == CNT_W'(1)) begin
          d_state_d = RESP;
          d_acc_c   = 1'b1;
        end else begin
          d_cnt_d = d_cnt - CNT_W'(1);
        end
      end
      default: d_state_d = IDLE;
    endcase
  end

  // data address decode, tohost routing and read data selection
  always_comb begin
    d_idx_c     = d_cur_c.addr >> OFF_W;
    d_host_c    = (d_idx_c == TOHOST_IDX);
    d_oor_c     = !d_host_c && (d_idx_c >= DEPTH_A);
    d_wr_c      = d_cur_c.we && !d_host_c && !d_oor_c;
    d_host_wr_c = d_cur_c.we && d_host_c && (|d_cur_c.be);
    if (d_cur_c.we || d_oor_c) d_rdata_c = '0;
    else if (d_host_c)         d_rdata_c = exit_code;
    else                       d_rdata_c = mem[d_idx_c[IDX_W-1:0]];
  end

  // data port state, response registers, memory write and completion register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state      <= IDLE;
      d_cnt        <= '0;
      d_req_q      <= '0;
      bus.d_ready  <= 1'b1;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= '0;
      bus.d_err    <= 1'b0;
      done         <= 1'b0;
      exit_code    <= '0;
    end else begin
      d_state      <= d_state_d;
      d_cnt        <= d_cnt_d;
      d_req_q      <= d_req_d;
      bus.d_ready  <= (d_state_d != BUSY);
      bus.d_rvalid <= d_acc_c;
      if (d_acc_c) begin
        bus.d_rdata <= d_rdata_c;
        bus.d_err   <= d_oor_c;
        if (d_host_wr_c) begin
          done      <= 1'b1;
          exit_code <= d_cur_c.wdata;
        end
        if (d_wr_c) begin
          for (int k = 0; k < int'(BE_W); k++) begin
            if (d_cur_c.be[k]) mem[d_idx_c[IDX_W-1:0]][8*k +: 8] <= d_cur_c.wdata[8*k +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_mem_model.sv
// Directed bench for rv_mem_model: an event-level model (pending response per
// port with due cycle, associative memory) is compared against the DUT every
// cycle, plus literal checks on the scenarios of interest. A second instance
// with D_WAIT=3 exercises reset during an in-flight write.
module tb_rv_mem_model;
  localparam int I_WAIT = 0;
  localparam int D_WAIT = 2;
  localparam int DEPTH  = 4096;
  localparam int TH_IDX = 32'h0000_F000 >> 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;
  logic        done, done2;
  logic [31:0] exit_code, exit_code2;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          model_en = 1'b0;

  rv_mem_model_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  rv_mem_model_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  rv_mem_model #(.I_WAIT(I_WAIT), .D_WAIT(D_WAIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .done(done), .exit_code(exit_code));

  rv_mem_model #(.I_WAIT(0), .D_WAIT(3), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .done(done2), .exit_code(exit_code2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } mreq_t;

  logic [31:0] mm [int];
  logic        m_done = 1'b0;
  logic [31:0] m_exit = '0;
  mreq_t       ip, dp;
  bit          i_has = 1'b0, d_has = 1'b0;
  int          i_free = 0, d_free = 0;

  function automatic logic [32:0] m_read(input logic [31:0] a);
    int w = int'(a >> 2);
    if (w == TH_IDX) return {1'b0, m_exit};
    if (w >= DEPTH)  return {1'b1, 32'h0};
    return {1'b0, (mm.exists(w) ? mm[w] : 32'h0)};
  endfunction

  // per-cycle compare, then accept new requests, then perform accesses due at this edge
  always @(negedge clk) begin
    if (model_en) begin
      bit          due;
      logic [32:0] r;
      logic [31:0] old;
      int          w;
      chk("i_ready", 32'(bus.i_ready), 32'(cyc >= i_free));
      due = i_has && (ip.due == cyc);
      chk("i_rvalid", 32'(bus.i_rvalid), 32'(due));
      if (due) begin
        chk("i_rdata", bus.i_rdata, ip.rdata);
        chk("i_err", 32'(bus.i_err), 32'(ip.err));
        i_has = 1'b0;
      end
      chk("d_ready", 32'(bus.d_ready), 32'(cyc >= d_free));
      due = d_has && (dp.due == cyc);
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(due));
      if (due) begin
        chk("d_rdata", bus.d_rdata, dp.rdata);
        chk("d_err", 32'(bus.d_err), 32'(dp.err));
        d_has = 1'b0;
      end
      chk("done", 32'(done), 32'(m_done));
      chk("exit_code", exit_code, m_exit);

      if (bus.i_valid && cyc >= i_free) begin
        ip.due = cyc + I_WAIT + 1; ip.addr = bus.i_addr; i_has = 1'b1; i_free = ip.due;
      end
      if (bus.d_valid && cyc >= d_free) begin
        dp.due = cyc + D_WAIT + 1; dp.addr = bus.d_addr; dp.we = bus.d_we;
        dp.be = bus.d_be; dp.wdata = bus.d_wdata; d_has = 1'b1; d_free = dp.due;
      end

      // instruction read first: it sees memory before a same-edge data write
      if (i_has && ip.due == cyc + 1) begin
        r = m_read(ip.addr); ip.err = r[32]; ip.rdata = r[31:0];
      end
      if (d_has && dp.due == cyc + 1) begin
        if (!dp.we) begin
          r = m_read(dp.addr); dp.err = r[32]; dp.rdata = r[31:0];
        end else begin
          w = int'(dp.addr >> 2);
          dp.rdata = '0;
          dp.err = (w != TH_IDX) && (w >= DEPTH);
          if (w == TH_IDX) begin
            if (dp.be != 4'b0) begin m_done = 1'b1; m_exit = dp.wdata; end
          end else if (!dp.err) begin
            old = mm.exists(w) ? mm[w] : 32'h0;
            for (int k = 0; k < 4; k++) if (dp.be[k]) old[8*k +: 8] = dp.wdata[8*k +: 8];
            mm[w] = old;
          end
        end
      end
    end
  end

  // ---------------- response capture ----------------
  logic [31:0] i_hist_data[$];
  int          i_hist_cyc[$];
  logic [31:0] last_d_rdata = '0;
  logic        last_d_err = 1'b0;
  int          last_d_cyc = -1;
  int          d2_cnt = 0;
  logic [31:0] d2_last = '0;

  always @(negedge clk) begin
    if (bus.i_rvalid) begin i_hist_data.push_back(bus.i_rdata); i_hist_cyc.push_back(cyc); end
    if (bus.d_rvalid) begin last_d_rdata = bus.d_rdata; last_d_err = bus.d_err; last_d_cyc = cyc; end
    if (bus2.d_rvalid) begin d2_cnt++; d2_last = bus2.d_rdata; end
  end

  // ---------------- stimulus tasks (called just after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i_req(input logic [31:0] a, output int acc);
    bit ok = 1'b0;
    acc = -1;
    bus.i_valid = 1'b1; bus.i_addr = a;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk); ok = bus.i_ready; if (ok) acc = cyc;
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    chk("i_accept", 32'(ok), 32'd1);
  endtask

  task automatic d_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output int acc);
    bit ok = 1'b0;
    acc = -1;
    bus.d_valid = 1'b1; bus.d_addr = a; bus.d_we = we; bus.d_be = be; bus.d_wdata = wd;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk); ok = bus.d_ready; if (ok) acc = cyc;
      @(posedge clk); #1;
    end
    bus.d_valid = 1'b0;
    chk("d_accept", 32'(ok), 32'd1);
  endtask

  task automatic d2_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bit ok = 1'b0;
    bus2.d_valid = 1'b1; bus2.d_addr = a; bus2.d_we = we; bus2.d_be = 4'hF; bus2.d_wdata = wd;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk); ok = bus2.d_ready;
      @(posedge clk); #1;
    end
    bus2.d_valid = 1'b0;
    chk("d2_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] prog [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193};

  initial begin
    int a, b, base, c0;
    int ia[4];
    bus.i_valid = 0; bus.i_addr = '0;
    bus.d_valid = 0; bus.d_addr = '0; bus.d_we = 0; bus.d_be = '0; bus.d_wdata = '0;
    bus2.i_valid = 0; bus2.i_addr = '0;
    bus2.d_valid = 0; bus2.d_addr = '0; bus2.d_we = 0; bus2.d_be = '0; bus2.d_wdata = '0;
    #1 rst = 1'b1; rst2 = 1'b1;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd1);
    chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    chk("rst_err", 32'(bus.i_err | bus.d_err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rst2 = 1'b0; model_en = 1'b1;

    // preload program words, then back-to-back instruction fetches
    for (int k = 0; k < 4; k++) d_req(32'(4 * k), 1'b1, 4'hF, prog[k], a);
    idle(4);
    base = i_hist_data.size();
    for (int k = 0; k < 4; k++) i_req(32'(4 * k), ia[k]);
    idle(3);
    chk("i_burst_count", 32'(i_hist_data.size() - base), 32'd4);
    chk("i_burst_b2b", 32'(ia[3] - ia[0]), 32'd3);
    if (i_hist_data.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("i_burst_data", i_hist_data[base + k], prog[k]);
        chk("i_burst_cyc", 32'(i_hist_cyc[base + k]), 32'(ia[0] + 1 + k));
      end
    end

    // byte-enabled write over an existing word, then read back with latency check
    d_req(32'h10, 1'b1, 4'hF, 32'h1122_3344, a); idle(3);
    d_req(32'h10, 1'b1, 4'b0101, 32'hDEAD_BEEF, a); idle(3);
    d_req(32'h10, 1'b0, 4'h0, 32'h0, a);
    @(negedge clk); chk("d_ready_wait1", 32'(bus.d_ready), 32'd0);
    @(negedge clk); chk("d_ready_wait2", 32'(bus.d_ready), 32'd0);
    @(negedge clk); chk("d_ready_resp", 32'(bus.d_ready), 32'd1);
    @(posedge clk); #1;
    chk("be_merge_data", last_d_rdata, 32'h11AD_33EF);
    chk("read_latency", 32'(last_d_cyc - a), 32'd3);

    // out-of-range read and write
    d_req(32'h4000, 1'b0, 4'h0, 32'h0, a); idle(4);
    chk("oor_rd_err", 32'(last_d_err), 32'd1);
    chk("oor_rd_data", last_d_rdata, 32'd0);
    d_req(32'h4000, 1'b1, 4'hF, 32'hCAFE_F00D, a); idle(4);
    chk("oor_wr_err", 32'(last_d_err), 32'd1);
    d_req(32'h0, 1'b0, 4'h0, 32'h0, a); idle(4);
    chk("oor_wr_no_alias", last_d_rdata, prog[0]);

    // zero byte enables: acknowledged, no change
    d_req(32'h10, 1'b1, 4'h0, 32'hFFFF_FFFF, a); idle(4);
    chk("be0_ack_cyc", 32'(last_d_cyc - a), 32'd3);
    d_req(32'h10, 1'b0, 4'h0, 32'h0, a); idle(4);
    chk("be0_unchanged", last_d_rdata, 32'h11AD_33EF);

    // same-edge instruction read and data write to one word
    d_req(32'h20, 1'b1, 4'hF, 32'h0, a); idle(3);
    base = i_hist_data.size();
    fork
      d_req(32'h20, 1'b1, 4'hF, 32'h13, a);
      begin @(posedge clk); @(posedge clk); #1; i_req(32'h20, b); end
    join
    idle(3);
    chk("same_edge_same_cycle", 32'(b), 32'(a + 2));
    chk("same_edge_old_data", i_hist_data[$], 32'h0);
    i_req(32'h20, b); idle(2);
    chk("same_edge_new_data", i_hist_data[$], 32'h13);

    // tohost completion register
    d_req(32'h0000_F000, 1'b1, 4'hF, 32'h1, a); idle(3);
    chk("tohost_done", 32'(done), 32'd1);
    chk("tohost_exit1", exit_code, 32'd1);
    d_req(32'h0000_F000, 1'b1, 4'hF, 32'h3, a); idle(3);
    chk("tohost_sticky", 32'(done), 32'd1);
    chk("tohost_exit3", exit_code, 32'd3);
    d_req(32'h0000_F000, 1'b0, 4'h0, 32'h0, a); idle(4);
    chk("tohost_rd_data", last_d_rdata, 32'd3);
    chk("tohost_rd_err", 32'(last_d_err), 32'd0);

    // reset during an in-flight write on the D_WAIT=3 instance
    d2_req(32'h0000_F000, 1'b1, 32'h7); idle(5);
    chk("d2_done_set", 32'(done2), 32'd1);
    d2_req(32'h40, 1'b1, 32'h55); idle(5);
    c0 = d2_cnt;
    d2_req(32'h40, 1'b1, 32'hAA);
    rst2 = 1'b1;
    idle(3);
    chk("d2_rst_done", 32'(done2), 32'd0);
    rst2 = 1'b0;
    idle(5);
    chk("d2_no_rvalid", 32'(d2_cnt - c0), 32'd0);
    chk("d2_ready", 32'(bus2.d_ready), 32'd1);
    chk("d2_done_clear", 32'(done2), 32'd0);
    d2_req(32'h40, 1'b0, 32'h0); idle(5);
    chk("d2_resp_count", 32'(d2_cnt - c0), 32'd1);
    chk("d2_word_kept", d2_last, 32'h55);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
